// File: rtl/gpu2d_pkg.sv
// Shared types and constants for the 2D GPU line-buffer path.
package gpu2d_pkg;

  localparam int LINE_W_MAX = 512;
  localparam int VRAM_AW    = 10;

  typedef logic [7:0] pixel_t;

  typedef enum logic {
    RENDER = 1'b0,
    DONE   = 1'b1
  } render_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Snapshot of controller state for observation by checkers.
  typedef struct packed {
    render_state_e render_state;
    scan_state_e   scan_state;
    logic          front_bank;
    logic [8:0]    x;
  } ctrl_dbg_t;

endpackage

// File: rtl/scanline_buf_ctrl.sv
// Ping-pong scanline controller: the 1024x8 VRAM holds two 512-byte line
// banks. The renderer fills the back bank through port A, scan-out reads
// (and optionally clears) the front bank through port B, and the banks
// swap on every line_start.
//
// Handshake: a renderer write transfers in any cycle where wr_valid and
// wr_ready are both high; wr_ready depends only on internal state, never
// on wr_valid. Writes with wr_x >= LINE_W complete the handshake but are
// dropped.
import gpu2d_pkg::*;

module scanline_buf_ctrl #(
  parameter int LINE_W    = 512,
  parameter int DATA_W    = 8,
  parameter int CLR_ON_RD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic              pix_en,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [8:0]        wr_x,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              line_done,
  output logic              front_bank,
  output logic              underrun,
  output logic              vram_we_a,
  output logic [9:0]        vram_addr_a,
  output logic [DATA_W-1:0] vram_d_a,
  output logic              vram_we_b,
  output logic [9:0]        vram_addr_b,
  output logic [DATA_W-1:0] vram_d_b,
  input  logic [DATA_W-1:0] vram_q_b,
  output ctrl_dbg_t         dbg
);

  localparam logic [9:0] LINE_W_V = 10'(LINE_W);
  localparam logic [8:0] X_LAST   = 9'(LINE_W - 1);

  render_state_e render_q, render_d;
  scan_state_e   scan_q, scan_d;
  logic [8:0]    x_q, x_d;
  logic          front_q, front_d;
  logic          rd_issue;
  logic          pix_valid_q;

  // State register for both FSMs, the scan x counter and the bank bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      render_q <= RENDER;
      scan_q   <= IDLE;
      x_q      <= '0;
      front_q  <= 1'b0;
    end else begin
      render_q <= render_d;
      scan_q   <= scan_d;
      x_q      <= x_d;
      front_q  <= front_d;
    end
  end

  // Next state: line_start overrides everything else (swap, restart scan).
  always_comb begin
    render_d = render_q;
    scan_d   = scan_q;
    x_d      = x_q;
    front_d  = front_q;
    if (render_q == RENDER && line_done) begin
      render_d = DONE;
    end
    if (rd_issue) begin
      if (x_q == X_LAST) begin
        scan_d = IDLE;
        x_d    = '0;
      end else begin
        x_d = x_q + 9'd1;
      end
    end
    if (line_start) begin
      front_d  = ~front_q;
      render_d = RENDER;
      scan_d   = SCAN;
      x_d      = '0;
    end
  end

  // Outputs: both VRAM ports are driven combinationally from current state.
  always_comb begin
    wr_ready    = (render_q == RENDER);
    vram_we_a   = wr_valid && wr_ready && ({1'b0, wr_x} < LINE_W_V);
    vram_addr_a = {~front_q, wr_x};
    vram_d_a    = wr_data;
    // A read on the swap cycle is suppressed; the new line starts next cycle.
    rd_issue    = (scan_q == SCAN) && pix_en && !line_start;
    vram_we_b   = rd_issue && (CLR_ON_RD != 0);
    vram_addr_b = {front_q, x_q};
    vram_d_b    = '0;
    underrun    = line_start && (render_q == RENDER) && !line_done;
  end

  // Read-valid flag tracks the VRAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
    end else begin
      pix_valid_q <= rd_issue;
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_data   = vram_q_b;
  assign front_bank = front_q;

  assign dbg.render_state = render_q;
  assign dbg.scan_state   = scan_q;
  assign dbg.front_bank   = front_q;
  assign dbg.x            = x_q;

endmodule

// File: tb/tb_scanline_buf_ctrl.sv
// Bench for scanline_buf_ctrl: two instances (LINE_W=512 and LINE_W=8)
// share stimulus; each has its own read-first VRAM and reference model.
import gpu2d_pkg::*;

module tb_scanline_buf_ctrl;

  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic          line_start = 1'b0;
  logic          pix_en     = 1'b0;
  logic          wr_valid   = 1'b0;
  logic          line_done  = 1'b0;
  logic [8:0]    wr_x       = '0;
  logic [DW-1:0] wr_data    = '0;

  // ---------------- per-instance outputs ----------------
  logic [DW-1:0] pix_data    [2];
  logic          pix_valid   [2];
  logic          wr_ready    [2];
  logic          front_bank  [2];
  logic          underrun    [2];
  logic          vram_we_a   [2];
  logic [9:0]    vram_addr_a [2];
  logic [DW-1:0] vram_d_a    [2];
  logic          vram_we_b   [2];
  logic [9:0]    vram_addr_b [2];
  logic [DW-1:0] vram_d_b    [2];
  logic [DW-1:0] vram_q_b    [2];
  ctrl_dbg_t     dbg         [2];

  scanline_buf_ctrl #(.LINE_W(512), .DATA_W(DW), .CLR_ON_RD(1)) dut_w512 (
    .clk(clk), .rst(rst), .line_start(line_start), .pix_en(pix_en),
    .pix_data(pix_data[0]), .pix_valid(pix_valid[0]),
    .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_x(wr_x), .wr_data(wr_data),
    .line_done(line_done), .front_bank(front_bank[0]), .underrun(underrun[0]),
    .vram_we_a(vram_we_a[0]), .vram_addr_a(vram_addr_a[0]), .vram_d_a(vram_d_a[0]),
    .vram_we_b(vram_we_b[0]), .vram_addr_b(vram_addr_b[0]), .vram_d_b(vram_d_b[0]),
    .vram_q_b(vram_q_b[0]), .dbg(dbg[0])
  );

  scanline_buf_ctrl #(.LINE_W(8), .DATA_W(DW), .CLR_ON_RD(1)) dut_w8 (
    .clk(clk), .rst(rst), .line_start(line_start), .pix_en(pix_en),
    .pix_data(pix_data[1]), .pix_valid(pix_valid[1]),
    .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_x(wr_x), .wr_data(wr_data),
    .line_done(line_done), .front_bank(front_bank[1]), .underrun(underrun[1]),
    .vram_we_a(vram_we_a[1]), .vram_addr_a(vram_addr_a[1]), .vram_d_a(vram_d_a[1]),
    .vram_we_b(vram_we_b[1]), .vram_addr_b(vram_addr_b[1]), .vram_d_b(vram_d_b[1]),
    .vram_q_b(vram_q_b[1]), .dbg(dbg[1])
  );

  // ---------------- VRAM models (read-first, 1-cycle latency) ----------------
  logic [DW-1:0] vmem [2][1024];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      vram_q_b[i] <= vmem[i][vram_addr_b[i]];
      if (vram_we_b[i]) vmem[i][vram_addr_b[i]] <= vram_d_b[i];
      if (vram_we_a[i]) vmem[i][vram_addr_a[i]] <= vram_d_a[i];
    end
  end

  // ---------------- reference model ----------------
  int            lw [2] = '{512, 8};
  logic [DW-1:0] mmem [2][1024];
  bit            m_front [2];
  bit            m_done  [2];
  bit            m_scan  [2];
  int            m_x     [2];
  bit            m_pv    [2];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string sfx(input int i);
    return (i == 0) ? "@w512" : "@w8";
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_front[i] = 1'b0;
      m_done[i]  = 1'b0;
      m_scan[i]  = 1'b0;
      m_x[i]     = 0;
      m_pv[i]    = 1'b0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    line_start = 1'b0; line_done = 1'b0; pix_en = 1'b0; wr_valid = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      check({"rst_front_bank", sfx(i)}, 32'(front_bank[i]), 32'd0);
      check({"rst_wr_ready", sfx(i)}, 32'(wr_ready[i]), 32'd1);
      check({"rst_pix_valid", sfx(i)}, 32'(pix_valid[i]), 32'd0);
      check({"rst_we_a", sfx(i)}, 32'(vram_we_a[i]), 32'd0);
      check({"rst_we_b", sfx(i)}, 32'(vram_we_b[i]), 32'd0);
      check({"rst_underrun", sfx(i)}, 32'(underrun[i]), 32'd0);
      check({"rst_scan_idle", sfx(i)}, 32'(dbg[i].scan_state), 32'(IDLE));
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock of stimulus; checks every output against the model.
  task automatic cycle(input bit ls, input bit ld, input bit pe, input bit wv,
                       input logic [8:0] wx, input logic [DW-1:0] wd);
    logic [9:0]    a;
    logic [DW-1:0] e;
    bit            rdy, we, iss;
    @(negedge clk);
    line_start = ls; line_done = ld; pix_en = pe;
    wr_valid = wv; wr_x = wx; wr_data = wd;
    #2;
    for (int i = 0; i < 2; i++) begin
      check({"pix_valid", sfx(i)}, 32'(pix_valid[i]), 32'(m_pv[i]));
      if (m_pv[i]) begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check({"pix_data", sfx(i)}, 32'(pix_data[i]), 32'(e));
      end
      check({"front_bank", sfx(i)}, 32'(front_bank[i]), 32'(m_front[i]));
      rdy = !m_done[i];
      check({"wr_ready", sfx(i)}, 32'(wr_ready[i]), 32'(rdy));
      check({"underrun", sfx(i)}, 32'(underrun[i]), 32'(ls && rdy && !ld));
      we = wv && rdy && (int'(wx) < lw[i]);
      check({"we_a", sfx(i)}, 32'(vram_we_a[i]), 32'(we));
      if (we) begin
        a = {~m_front[i], wx};
        check({"addr_a", sfx(i)}, 32'(vram_addr_a[i]), 32'(a));
        check({"d_a", sfx(i)}, 32'(vram_d_a[i]), 32'(wd));
        mmem[i][a] = wd;
      end
      iss = m_scan[i] && pe && !ls;
      check({"we_b", sfx(i)}, 32'(vram_we_b[i]), 32'(iss));
      if (iss) begin
        a = {m_front[i], 9'(m_x[i])};
        check({"addr_b", sfx(i)}, 32'(vram_addr_b[i]), 32'(a));
        check({"d_b", sfx(i)}, 32'(vram_d_b[i]), 32'd0);
        if (i == 0) exp_q0.push_back(mmem[i][a]);
        else        exp_q1.push_back(mmem[i][a]);
        mmem[i][a] = '0;
        m_x[i]++;
        if (m_x[i] == lw[i]) m_scan[i] = 1'b0;
      end
      m_pv[i] = iss;
      if (ld) m_done[i] = 1'b1;
      if (ls) begin
        m_front[i] = ~m_front[i];
        m_done[i]  = 1'b0;
        m_scan[i]  = 1'b1;
        m_x[i]     = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 9'd0, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  int pulses;
  int diffs;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) begin
        vmem[i][j] = '0;
        mmem[i][j] = '0;
      end
    model_reset();

    // Reset values, then pix_en before any line_start is ignored.
    do_reset();
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 9'd0, 8'h00);

    // Write 0x5A at x=3, finish, swap, read four pixels.
    cycle(0, 0, 0, 1, 9'd3, 8'h5A);
    cycle(0, 1, 0, 0, 9'd0, 8'h00);
    cycle(1, 0, 0, 0, 9'd0, 8'h00);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 0, 9'd0, 8'h00);
    idle(1);
    check("front_after_swap@w512", 32'(front_bank[0]), 32'd1);
    check("cleared_0x203@w512", 32'(vmem[0][10'h203]), 32'd0);

    // Swap without line_done: underrun, swap still happens.
    cycle(1, 0, 0, 0, 9'd0, 8'h00);
    idle(1);

    // Out-of-line x: handshake completes, data dropped (w8), boundary x=511 (w512).
    cycle(0, 0, 0, 1, 9'd300, 8'hA5);
    cycle(0, 0, 0, 1, 9'd511, 8'h3C);
    cycle(0, 0, 0, 1, 9'd8, 8'h77);
    cycle(0, 0, 0, 1, 9'd7, 8'h11);

    // LINE_W=8: 10 consecutive pix_en give exactly 8 pixels, scan returns to IDLE.
    cycle(0, 1, 0, 0, 9'd0, 8'h00);
    cycle(1, 0, 0, 0, 9'd0, 8'h00);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 1, 0, 9'd0, 8'h00);
      pulses += int'(pix_valid[1]);
    end
    idle(1);
    pulses += int'(pix_valid[1]);
    check("pix_pulses@w8", 32'(pulses), 32'd8);
    check("scan_idle@w8", 32'(dbg[1].scan_state), 32'(IDLE));

    // line_done with line_start in the same cycle plus a write at the swap.
    cycle(0, 0, 0, 1, 9'd2, 8'h21);
    cycle(1, 1, 0, 1, 9'd5, 8'hC3);
    cycle(0, 0, 1, 0, 9'd0, 8'h00);
    // Mid-line line_start truncates and restarts at x=0.
    cycle(0, 0, 1, 0, 9'd0, 8'h00);
    cycle(0, 0, 1, 0, 9'd0, 8'h00);
    cycle(1, 0, 1, 0, 9'd0, 8'h00);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0, 9'd0, 8'h00);
    cycle(1, 0, 0, 0, 9'd0, 8'h00);
    for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0, 9'd0, 8'h00);

    // Reset mid-scan: state returns to reset values, VRAM kept.
    cycle(1, 0, 1, 1, 9'd4, 8'h99);
    cycle(0, 0, 1, 0, 9'd0, 8'h00);
    do_reset();
    cycle(1, 0, 0, 0, 9'd0, 8'h00);
    for (int k = 0; k < 9; k++) cycle(0, 0, 1, 0, 9'd0, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      cycle($urandom_range(0, 39) == 0,
            $urandom_range(0, 29) == 0,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511))
                                        : 9'($urandom_range(0, 9)),
            8'($urandom_range(0, 255)));
    end
    idle(2);
    @(posedge clk);
    #1;

    // Final VRAM image must match the model's view of memory.
    for (int i = 0; i < 2; i++) begin
      diffs = 0;
      for (int j = 0; j < 1024; j++)
        if (vmem[i][j] !== mmem[i][j]) diffs++;
      check({"vram_image_diffs", sfx(i)}, 32'(diffs), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no end expected end by %0t", $time);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
